// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce and auto-repeat a raw push-button
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES      = 500000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000,
    parameter int ACTIVE_LOW           = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(RPT_MAX + 1);

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);
    localparam logic          RELEASED    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REPEAT,
        RELEASE_WAIT
    } state_t;

    state_t        state;
    state_t        resume_state;
    logic [DW-1:0] deb_cnt;
    logic [RW-1:0] rpt_cnt;
    logic          sync1;
    logic          sync2;
    logic          s_btn;

    assign s_btn = sync2 ^ RELEASED;

    // deb_cnt counts stable samples including the one that left the previous state,
    // so a threshold hit happens on the sample that would make it DEBOUNCE_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1         <= RELEASED;
            sync2         <= RELEASED;
            state         <= IDLE;
            resume_state  <= HELD;
            deb_cnt       <= '0;
            rpt_cnt       <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            sync1         <= button_raw;
            sync2         <= sync1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    btn_level <= 1'b0;
                    if (s_btn) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= DW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!s_btn) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state       <= HELD;
                        press_pulse <= 1'b1;
                        btn_level   <= 1'b1;
                        rpt_cnt     <= '0;
                        deb_cnt     <= '0;
                    end else if (deb_cnt != '1) begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!s_btn) begin
                        state        <= RELEASE_WAIT;
                        resume_state <= HELD;
                        deb_cnt      <= DW'(1);
                    end else if (rpt_cnt == DELAY_LAST) begin
                        state       <= REPEAT;
                        long_press  <= 1'b1;
                        rpt_cnt     <= '0;
                        press_pulse <= repeat_en;
                    end else if (rpt_cnt != '1) begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!s_btn) begin
                        state        <= RELEASE_WAIT;
                        resume_state <= REPEAT;
                        deb_cnt      <= DW'(1);
                    end else if (rpt_cnt == PERIOD_LAST) begin
                        rpt_cnt     <= '0;
                        press_pulse <= repeat_en;
                    end else if (rpt_cnt != '1) begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                RELEASE_WAIT: begin
                    // rpt_cnt is left untouched so a release bounce resumes the same timing
                    if (s_btn) begin
                        state   <= resume_state;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        btn_level     <= 1'b0;
                        long_press    <= 1'b0;
                        deb_cnt       <= '0;
                        rpt_cnt       <= '0;
                    end else if (deb_cnt != '1) begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    deb_cnt <= '0;
                    rpt_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic button_raw;
    logic repeat_en;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    int checks = 0;
    int errors = 0;
    int press_total = 0;
    int release_total = 0;
    logic prev_press = 1'b0;

    button_conditioner #(
        .DEBOUNCE_CYCLES      (4),
        .REPEAT_DELAY_CYCLES  (10),
        .REPEAT_PERIOD_CYCLES (3),
        .ACTIVE_LOW           (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .button_raw    (button_raw),
        .repeat_en     (repeat_en),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse accounting and exclusivity, sampled mid-cycle
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("press_release_exclusive", 32'(press_pulse & release_pulse), 32'd0);
            chk("press_not_adjacent", 32'(press_pulse & prev_press), 32'd0);
            if (press_pulse === 1'b1) press_total++;
            if (release_pulse === 1'b1) release_total++;
        end
        prev_press = press_pulse;
    end

    initial begin
        reset      = 1'b0;
        button_raw = 1'b1;
        repeat_en  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_level", 32'(btn_level), 32'd0);
        chk("rst_press", 32'(press_pulse), 32'd0);
        chk("rst_release", 32'(release_pulse), 32'd0);
        chk("rst_long", 32'(long_press), 32'd0);
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("rst_exit_press", 32'(press_pulse), 32'd0);
            chk("rst_exit_level", 32'(btn_level), 32'd0);
        end

        // T1 clean press then clean release
        button_raw = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t1_press", 32'(press_pulse), 32'(i == 6));
            chk("t1_level", 32'(btn_level), 32'(i >= 6));
        end
        button_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t1_release", 32'(release_pulse), 32'(i == 6));
            chk("t1_rel_level", 32'(btn_level), 32'(i < 6));
            chk("t1_rel_press", 32'(press_pulse), 32'd0);
        end

        // T2 bounce rejection: 3 low, 1 high, 3 low, then high
        for (int i = 1; i <= 14; i++) begin
            button_raw = (i <= 3 || (i >= 5 && i <= 7)) ? 1'b0 : 1'b1;
            tick();
            chk("t2_press", 32'(press_pulse), 32'd0);
            chk("t2_level", 32'(btn_level), 32'd0);
        end

        // T3 auto-repeat over a 40-cycle hold
        repeat_en  = 1'b1;
        button_raw = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk("t3_press", 32'(press_pulse), 32'(i == 6 || (i >= 16 && (i - 16) % 3 == 0)));
            chk("t3_long", 32'(long_press), 32'(i >= 16));
        end

        // T4 release bounce inside REPEAT, then real release
        for (int i = 1; i <= 12; i++) begin
            button_raw = (i <= 2) ? 1'b1 : 1'b0;
            tick();
            chk("t4_press", 32'(press_pulse), 32'(i == 6 || i == 9 || i == 12));
            chk("t4_no_release", 32'(release_pulse), 32'd0);
            chk("t4_long", 32'(long_press), 32'd1);
            chk("t4_level", 32'(btn_level), 32'd1);
        end
        button_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t4_release", 32'(release_pulse), 32'(i == 6));
            chk("t4_rel_press", 32'(press_pulse), 32'd0);
            chk("t4_rel_level", 32'(btn_level), 32'(i < 6));
            chk("t4_rel_long", 32'(long_press), 32'(i < 6));
        end

        // T5 repeat gating, re-enabled mid-period
        repeat_en  = 1'b0;
        button_raw = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            chk("t5_press", 32'(press_pulse), 32'(i == 6 || (i >= 25 && (i - 25) % 3 == 0)));
            chk("t5_long", 32'(long_press), 32'(i >= 16));
            if (i == 23) repeat_en = 1'b1;
        end
        repeat_en  = 1'b0;
        button_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t5_release", 32'(release_pulse), 32'(i == 6));
            chk("t5_rel_press", 32'(press_pulse), 32'd0);
        end

        // T6 async reset mid-PRESS_WAIT, then restart with button held
        button_raw = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        reset = 1'b0;
        #1;
        chk("t6a_level", 32'(btn_level), 32'd0);
        chk("t6a_press", 32'(press_pulse), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("t6a_press_after", 32'(press_pulse), 32'(i == 6));
            chk("t6a_release", 32'(release_pulse), 32'd0);
            chk("t6a_long", 32'(long_press), 32'(i >= 16));
        end

        // T6 async reset mid-REPEAT
        reset = 1'b0;
        #1;
        chk("t6b_level", 32'(btn_level), 32'd0);
        chk("t6b_long", 32'(long_press), 32'd0);
        chk("t6b_press", 32'(press_pulse), 32'd0);
        chk("t6b_release", 32'(release_pulse), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t6b_press_after", 32'(press_pulse), 32'(i == 6));
            chk("t6b_release_after", 32'(release_pulse), 32'd0);
            chk("t6b_level_after", 32'(btn_level), 32'(i >= 6));
        end

        tick();
        chk("total_press_pulses", 32'(press_total), 32'd19);
        chk("total_release_pulses", 32'(release_total), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
